// File: rtl/add_button_conditioner.sv
// rtl/add_button_conditioner.sv - synchronise, debounce and pulse-shape an active-low add pushbutton
//
// Conditions a raw active-low pushbutton into one add strobe per accepted press.
// Optional auto-repeat issues further strobes while the button stays held.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   btn_n         in   raw asynchronous pushbutton, 0 = pressed
//   pressed       out  debounced level, high while the press is accepted
//   add_pulse     out  single-cycle add strobe (press or repeat)
//   add_n         out  registered inverse of add_pulse, counter enable (active low)
//   release_pulse out  single-cycle strobe when a release is accepted
module add_button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic add_pulse,
    output logic add_n,
    output logic release_pulse
);

    // Each counter only has to reach its parameter minus one.
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HELD,
        REPEAT,
        DISARM
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sync_ff;
    logic [DEB_W-1:0]        deb_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [REP_W-1:0]        rep_cnt;
    logic                    btn_s;

    // Synchroniser resets to the released level so a held button after reset
    // is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign btn_s = ~sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            pressed       <= 1'b0;
            add_pulse     <= 1'b0;
            add_n         <= 1'b1;
            release_pulse <= 1'b0;
        end else begin
            add_pulse     <= 1'b0;
            release_pulse <= 1'b0;
            // One cycle behind add_pulse so the two are never active together.
            add_n         <= ~add_pulse;

            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state   <= ARM;
                        deb_cnt <= DEB_W'(1);
                    end
                end

                ARM: begin
                    if (!btn_s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        pressed   <= 1'b1;
                        add_pulse <= 1'b1;
                        deb_cnt   <= '0;
                        hold_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state    <= DISARM;
                        deb_cnt  <= DEB_W'(1);
                        hold_cnt <= '0;
                    end else if (REPEAT_EN != 0) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= REPEAT;
                            add_pulse <= 1'b1;
                            hold_cnt  <= '0;
                            rep_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end

                REPEAT: begin
                    if (!btn_s) begin
                        state   <= DISARM;
                        deb_cnt <= DEB_W'(1);
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_LAST) begin
                        add_pulse <= 1'b1;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end

                DISARM: begin
                    // A return to pressed here is release bounce: resume holding
                    // without a new add strobe.
                    if (btn_s) begin
                        state    <= HELD;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                        deb_cnt       <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    pressed  <= 1'b0;
                    deb_cnt  <= '0;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_button_conditioner.sv
// tb/tb_add_button_conditioner.sv - self-checking bench for add_button_conditioner
module tb_add_button_conditioner;

    localparam int SS   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b1;

    // Index 0: REPEAT_EN = 0, index 1: REPEAT_EN = 1.
    wire [1:0] pr;
    wire [1:0] ap;
    wire [1:0] an;
    wire [1:0] rp;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain delay line for the synchroniser, then
    // "flip after DEB consecutive opposite samples" for debouncing, and an age
    // counter since the last steady (re)entry into the held level for repeats.
    bit       msync [SS];
    bit       mp;
    int       run;
    int       age;
    bit       prev_s;
    bit [1:0] e_add;
    bit [1:0] e_addn;
    bit       e_rel;

    always #5 clk = ~clk;

    add_button_conditioner #(
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .pressed(pr[0]), .add_pulse(ap[0]), .add_n(an[0]), .release_pulse(rp[0])
    );

    add_button_conditioner #(
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut1 (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .pressed(pr[1]), .add_pulse(ap[1]), .add_n(an[1]), .release_pulse(rp[1])
    );

    task automatic step(input logic b, input logic r);
        bit s;
        btn_n = b;
        rst   = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < SS; i++) msync[i] = 1'b1;
            mp = 0; run = 0; age = 0; prev_s = 0;
            e_add = 2'b00; e_addn = 2'b11; e_rel = 0;
        end else begin
            s = ~msync[SS-1];
            for (int i = SS - 1; i > 0; i--) msync[i] = msync[i-1];
            msync[0] = b;
            e_addn = ~e_add;
            e_add  = 2'b00;
            e_rel  = 0;
            if (!mp) begin
                run = s ? run + 1 : 0;
                if (run == DEB) begin
                    mp = 1; run = 0; age = 0; e_add = 2'b11;
                end
            end else if (!s) begin
                run = run + 1;
                if (run == DEB) begin
                    mp = 0; run = 0; e_rel = 1;
                end
            end else begin
                run = 0;
                age = prev_s ? age + 1 : 0;
                if (age >= HOLD && (age - HOLD) % REP == 0) e_add[1] = 1'b1;
            end
            prev_s = s;
        end
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 3 * DEB + 2 * SS; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(i[0], (i < 3) ? 1'b1 : 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== 4'b0010)
                    $display("FAIL reset dut%0d cycle %0d: got %b required 0010", k, i, {pr[k], ap[k], an[k], rp[k]});
                else n_pass++;
            end
        end
        settle();
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pulse_edge = -1;
        int rel_edge = -1;
        settle();
        for (int e = 0; e < 36; e++) begin
            step((e < 20) ? 1'b0 : 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                    $display("FAIL clean_press dut%0d edge %0d: got %b required %b", k, e, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                else n_pass++;
            end
            if (ap[0]) begin pulses++; pulse_edge = e; end
            if (rp[0]) rel_edge = e;
        end
        n_checks++;
        if (pulses !== 1 || pulse_edge !== 5) $display("FAIL clean_press_pulse: got %0d pulses last at e%0d, required 1 at e5", pulses, pulse_edge);
        else n_pass++;
        n_checks++;
        if (rel_edge !== 25) $display("FAIL clean_press_release: got e%0d required e25", rel_edge);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int lows [3] = '{3, 2, 1};
        int seen;
        for (int g = 0; g < 3; g++) begin
            settle();
            seen = 0;
            for (int e = 0; e < lows[g] + 10; e++) begin
                step((e < lows[g]) ? 1'b0 : 1'b1, 1'b0);
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                        $display("FAIL glitch%0d dut%0d edge %0d: got %b required %b", lows[g], k, e, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                    else n_pass++;
                    if (pr[k] || ap[k]) seen++;
                end
            end
            n_checks++;
            if (seen !== 0) $display("FAIL glitch%0d_rejected: got %0d active samples required 0", lows[g], seen);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        bit pat [5] = '{0, 1, 0, 1, 0};
        int pulses = 0;
        int pulse_edge = -1;
        settle();
        for (int e = 0; e < 45; e++) begin
            step((e < 5) ? pat[e] : ((e <= 24) ? 1'b0 : 1'b1), 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                    $display("FAIL bounce dut%0d edge %0d: got %b required %b", k, e, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                else n_pass++;
            end
            if (ap[0]) begin pulses++; pulse_edge = e; end
        end
        n_checks++;
        if (pulses !== 1 || pulse_edge !== 9) $display("FAIL bounce_pulse: got %0d pulses last at e%0d, required 1 at e9", pulses, pulse_edge);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int want [6] = '{5, 13, 17, 21, 25, 29};
        int got [$];
        int enables = 0;
        settle();
        for (int e = 0; e < 45; e++) begin
            step((e < 30) ? 1'b0 : 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                    $display("FAIL repeat dut%0d edge %0d: got %b required %b", k, e, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                else n_pass++;
            end
            if (ap[1]) got.push_back(e);
            if (!an[1]) enables++;
        end
        n_checks++;
        if (got.size() !== 6) $display("FAIL repeat_count: got %0d pulses required 6", got.size());
        else n_pass++;
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== want[i]) $display("FAIL repeat_edge%0d: got e%0d required e%0d", i, got[i], want[i]);
            else n_pass++;
        end
        n_checks++;
        if (enables !== 6) $display("FAIL repeat_counter_total: got %0d required 6", enables);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int edges [$];
        int enables = 0;
        settle();
        for (int e = 0; e < 46; e++) begin
            step((e <= 30) ? 1'b0 : 1'b1, (e == 10) ? 1'b1 : 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                    $display("FAIL mid_reset dut%0d edge %0d: got %b required %b", k, e, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                else n_pass++;
            end
            if (e == 10) begin
                n_checks++;
                if ({pr[0], ap[0], an[0], rp[0]} !== 4'b0010) $display("FAIL mid_reset_outputs: got %b required 0010", {pr[0], ap[0], an[0], rp[0]});
                else n_pass++;
            end
            if (ap[0]) edges.push_back(e);
            if (!an[0]) enables++;
        end
        n_checks++;
        if (edges.size() !== 2 || edges[1] !== 16) $display("FAIL mid_reset_repress: got %0d pulses, second at e%0d, required 2 with second at e16", edges.size(), (edges.size() > 1) ? edges[1] : -1);
        else n_pass++;
        n_checks++;
        if (enables !== 2) $display("FAIL mid_reset_counter_total: got %0d required 2", enables);
        else n_pass++;
    endtask

    task automatic test_random();
        int  left = 0;
        bit  lvl = 1;
        for (int c = 0; c < 1500; c++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
            end
            left--;
            step(lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({pr[k], ap[k], an[k], rp[k]} !== {mp, e_add[k], e_addn[k], e_rel})
                    $display("FAIL random dut%0d cycle %0d: got %b required %b", k, c, {pr[k], ap[k], an[k], rp[k]}, {mp, e_add[k], e_addn[k], e_rel});
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_repeat();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
